alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational RISC-V ALU (5-bit ALUOp, 32-bit A/B, Result, Flag) between two requesters.
//  Typical pair: the main execute path and a secondary unit such as address-gen or debug.
//  Arbitrates round-robin, latches operands, drives the external ALU, then registers Result/Flag.
//  Returns the registered result to the winner over a valid/ready response channel.
// PARAMETERS
//  XLEN    32  operand/result width
//  OP_W    5   ALUOp width
// PORTS
//  clk            in   1     clock, all state on rising edge
//  rst_n          in   1     asynchronous, active-low reset
//  reqN_valid     in   1     (N=0,1) request present; must not depend on reqN_ready
//  reqN_ready     out  1     request accepted this cycle
//  reqN_op        in   OP_W  ALUOp code
//  reqN_a/reqN_b  in   XLEN  operands
//  respN_valid    out  1     response for requester N available
//  respN_ready    in   1     requester N consumes response
//  resp_result    out  XLEN  shared registered result, meaningful when any respN_valid
//  resp_flag      out  1     shared registered flag
//  alu_op_o       out  OP_W  to shared ALU ALUOp
//  alu_a_o/alu_b_o out XLEN  to shared ALU A/B
//  alu_result_i   in   XLEN  from ALU Result
//  alu_flag_i     in   1     from ALU Flag
//  busy           out  1     state != IDLE
// BEHAVIOUR
//  Reset (async assert): state=IDLE, last_grant=1 so port 0 wins first contention.
//   All outputs 0 (ready, resp_valid, resp_result, resp_flag, alu_*_o, busy); in-flight op discarded.
//  FSM IDLE -> EXEC -> RESP -> IDLE.
//  IDLE:
//   grant = only valid port; if both valid, port != last_grant.
//   reqG_ready=1 (combinational) for the granted port only; other ready=0.
//   On the edge with valid&ready: latch op/a/b and id, set last_grant=id, go EXEC.
//  EXEC (1 cycle):
//   alu_*_o driven from latched registers (never combinationally from req ports).
//   Capture alu_result_i/alu_flag_i into resp_result/resp_flag at cycle end; go RESP.
//  RESP:
//   resp{id}_valid=1, other resp_valid=0; result/flag stable until the handshake.
//   On resp_ready go IDLE. No new request accepted in RESP (ready=0 in EXEC/RESP).
//  Latency: accept at edge T -> respN_valid high from edge T+2. Throughput 1 op / 3 cycles min.
//  alu_*_o hold last latched values outside EXEC (no toggling in IDLE).
//  Result/flag are passed through unmodified; legal ALUOp codes:
//   ADD 00000, SUB 01000, XOR 00100, OR 00110, AND 00111, SRA 01101, SRL 00101, SLL 00001,
//   LTS 11100, LTU 11110, GES 11101, GEU 11111, EQ 11000, NE 11001, SLTS 00010, SLTU 00011.
//   Comparison ops (LTS..NE) yield result 0 and the compare outcome on flag.
//  Req valid dropped without ready: no effect. Losing requester keeps waiting.
//   Round-robin guarantees service within one other op.
//  Reset mid-EXEC/RESP: response never issued; requester must re-issue.
// CONFIGURATION
//  ALU_ARB_OPCHK_EN defined: opcode checked at acceptance; ALU inputs still driven.
//   Illegal code (e.g. 01111) is returned with resp_result=0, resp_flag=0, and output resp_err=1.
//   resp_err is valid with respN_valid; same latency.
//  Not defined: no check, no resp_err port; ALU output returned whatever the code.
// TESTING
//  1. req0 ADD a=5 b=7, resp0_ready=1 -> req0_ready at T, resp0_valid at T+2, result=12, flag=0.
//  2. req0 & req1 valid same cycle after reset -> port0 served first, then port1.
//     Repeat contention -> port1 first.
//  3. req1 LTS a=32'hFFFFFFFF b=1 -> result=0, flag=1; GEU same operands -> flag=1.
//  4. resp0_ready held 0 for 4 cycles -> resp0_valid, result, flag stable.
//     req1 stays unready until IDLE.
//  5. rst_n pulsed low during EXEC -> all outputs 0 immediately, no response.
//     Next req0 SUB 3-5 -> 32'hFFFFFFFE.
//  6. ALU_ARB_OPCHK_EN: op=01111 -> result=0, flag=0, resp_err=1.
//     Following legal op -> resp_err=0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one external combinational ALU between two requesters
// Optional opcode legality check enabled by defining ALU_ARB_OPCHK_EN.
module alu_share_arbiter #(
   parameter int XLEN = 32,
   parameter int OP_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [OP_W-1:0] req0_op,
   input  logic [XLEN-1:0] req0_a,
   input  logic [XLEN-1:0] req0_b,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [OP_W-1:0] req1_op,
   input  logic [XLEN-1:0] req1_a,
   input  logic [XLEN-1:0] req1_b,
   output logic            resp0_valid,
   input  logic            resp0_ready,
   output logic            resp1_valid,
   input  logic            resp1_ready,
   output logic [XLEN-1:0] resp_result,
   output logic            resp_flag,
   output logic [OP_W-1:0] alu_op_o,
   output logic [XLEN-1:0] alu_a_o,
   output logic [XLEN-1:0] alu_b_o,
   input  logic [XLEN-1:0] alu_result_i,
   input  logic            alu_flag_i,
`ifdef ALU_ARB_OPCHK_EN
   output logic            resp_err,
`endif
   output logic            busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t          state, state_nx;
   logic            last_grant;
   logic            gnt;
   logic            accept;
   logic            id_q;
   logic [OP_W-1:0] op_q;
   logic [XLEN-1:0] a_q, b_q;
   logic [OP_W-1:0] sel_op;

   // Port 1 wins only when it is alone or port 0 was served last.
   always_comb begin
      gnt = 1'b0;
      if (req0_valid && req1_valid) gnt = ~last_grant;
      else if (req1_valid)          gnt = 1'b1;
      sel_op     = gnt ? req1_op : req0_op;
      accept     = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      state_nx   = state;
      case (state)
         IDLE: begin
            req0_ready = rst_n & req0_valid & ~gnt;
            req1_ready = rst_n & req1_valid & gnt;
            if (req0_valid || req1_valid) begin
               accept   = 1'b1;
               state_nx = EXEC;
            end
         end
         EXEC: state_nx = RESP;
         RESP: if (id_q ? resp1_ready : resp0_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

`ifdef ALU_ARB_OPCHK_EN
   logic err_q;

   function automatic logic legal_op(input logic [OP_W-1:0] op);
      case (op)
         OP_W'(5'b00000), OP_W'(5'b01000), OP_W'(5'b00100), OP_W'(5'b00110),
         OP_W'(5'b00111), OP_W'(5'b01101), OP_W'(5'b00101), OP_W'(5'b00001),
         OP_W'(5'b11100), OP_W'(5'b11110), OP_W'(5'b11101), OP_W'(5'b11111),
         OP_W'(5'b11000), OP_W'(5'b11001), OP_W'(5'b00010), OP_W'(5'b00011):
            legal_op = 1'b1;
         default: legal_op = 1'b0;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q    <= 1'b0;
         resp_err <= 1'b0;
      end else begin
         if (accept)        err_q    <= ~legal_op(sel_op);
         if (state == EXEC) resp_err <= err_q;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         id_q        <= 1'b0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         resp_result <= '0;
         resp_flag   <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            id_q       <= gnt;
            last_grant <= gnt;
            op_q       <= sel_op;
            a_q        <= gnt ? req1_a : req0_a;
            b_q        <= gnt ? req1_b : req0_b;
         end
         if (state == EXEC) begin
`ifdef ALU_ARB_OPCHK_EN
            resp_result <= err_q ? '0 : alu_result_i;
            resp_flag   <= err_q ? 1'b0 : alu_flag_i;
`else
            resp_result <= alu_result_i;
            resp_flag   <= alu_flag_i;
`endif
         end
      end
   end

   // ALU inputs come only from the operand registers, so they stay quiet outside EXEC.
   assign alu_op_o    = op_q;
   assign alu_a_o     = a_q;
   assign alu_b_o     = b_q;
   assign resp0_valid = (state == RESP) && !id_q;
   assign resp1_valid = (state == RESP) && id_q;
   assign busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter with a behavioural ALU
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [4:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
   logic [31:0] resp_result;
   logic        resp_flag;
   logic [4:0]  alu_op_o;
   logic [31:0] alu_a_o, alu_b_o, alu_result_i;
   logic        alu_flag_i;
   logic        busy;
`ifdef ALU_ARB_OPCHK_EN
   logic        resp_err;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_share_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .resp_result(resp_result), .resp_flag(resp_flag),
      .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
      .alu_result_i(alu_result_i), .alu_flag_i(alu_flag_i),
`ifdef ALU_ARB_OPCHK_EN
      .resp_err(resp_err),
`endif
      .busy(busy)
   );

   // Behavioural RISC-V ALU; unknown codes produce a marker value.
   always_comb begin
      alu_result_i = 32'h0;
      alu_flag_i   = 1'b0;
      case (alu_op_o)
         5'b00000: alu_result_i = alu_a_o + alu_b_o;
         5'b01000: alu_result_i = alu_a_o - alu_b_o;
         5'b00100: alu_result_i = alu_a_o ^ alu_b_o;
         5'b00110: alu_result_i = alu_a_o | alu_b_o;
         5'b00111: alu_result_i = alu_a_o & alu_b_o;
         5'b01101: alu_result_i = $signed(alu_a_o) >>> alu_b_o[4:0];
         5'b00101: alu_result_i = alu_a_o >> alu_b_o[4:0];
         5'b00001: alu_result_i = alu_a_o << alu_b_o[4:0];
         5'b11100: alu_flag_i = $signed(alu_a_o) < $signed(alu_b_o);
         5'b11110: alu_flag_i = alu_a_o < alu_b_o;
         5'b11101: alu_flag_i = $signed(alu_a_o) >= $signed(alu_b_o);
         5'b11111: alu_flag_i = alu_a_o >= alu_b_o;
         5'b11000: alu_flag_i = alu_a_o == alu_b_o;
         5'b11001: alu_flag_i = alu_a_o != alu_b_o;
         5'b00010: alu_result_i = {31'b0, $signed(alu_a_o) < $signed(alu_b_o)};
         5'b00011: alu_result_i = {31'b0, alu_a_o < alu_b_o};
         default:  alu_result_i = 32'hDEADBEEF;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic set_req(input bit p, input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      if (p) begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
      else   begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
   endtask

   // Single-requester transaction: ready in cycle T, EXEC in T+1, response in T+2.
   task automatic run_op(input bit p, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ef, input logic eerr);
      int n = 0;
      @(negedge clk);
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      set_req(p, 1'b1, op, a, b);
      #1;
      while (!(p ? req1_ready : req0_ready) && n < 10) begin
         @(negedge clk); n++;
      end
      chk("ready_wait", 32'(n), 32'd0);
      @(posedge clk); #1;
      set_req(p, 1'b0, 5'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("exec_busy", {31'b0, busy}, 32'd1);
      chk("exec_no_resp", {30'b0, resp1_valid, resp0_valid}, 32'd0);
      chk("exec_alu_op", {27'b0, alu_op_o}, {27'b0, op});
      chk("exec_alu_a", alu_a_o, a);
      chk("exec_alu_b", alu_b_o, b);
      @(negedge clk);
      chk("resp_valid", {30'b0, resp1_valid, resp0_valid}, p ? 32'd2 : 32'd1);
      chk("resp_result", resp_result, er);
      chk("resp_flag", {31'b0, resp_flag}, {31'b0, ef});
`ifdef ALU_ARB_OPCHK_EN
      chk("resp_err", {31'b0, resp_err}, {31'b0, eerr});
`else
      if (eerr) chk("resp_err_unexpected", 32'd0, 32'd1);
`endif
      @(posedge clk);
      @(negedge clk);
      chk("back_idle", {31'b0, busy}, 32'd0);
   endtask

   // Both ports request together; 'first' is the port expected to win.
   task automatic contend(input bit first);
      bit second;
      second = ~first;
      @(negedge clk);
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      set_req(1'b0, 1'b1, 5'b00000, 32'd1, 32'd2);
      set_req(1'b1, 1'b1, 5'b00000, 32'd10, 32'd20);
      #1;
      chk("cont_ready", {30'b0, req1_ready, req0_ready}, first ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      set_req(first, 1'b0, 5'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("cont_loser_wait_exec", {30'b0, req1_ready, req0_ready}, 32'd0);
      @(negedge clk);
      chk("cont_first_resp", {30'b0, resp1_valid, resp0_valid}, first ? 32'd2 : 32'd1);
      chk("cont_first_result", resp_result, first ? 32'd30 : 32'd3);
      chk("cont_loser_wait_resp", {30'b0, req1_ready, req0_ready}, 32'd0);
      @(negedge clk);
      chk("cont_second_ready", {30'b0, req1_ready, req0_ready}, second ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      set_req(second, 1'b0, 5'b0, 32'h0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      chk("cont_second_resp", {30'b0, resp1_valid, resp0_valid}, second ? 32'd2 : 32'd1);
      chk("cont_second_result", resp_result, second ? 32'd30 : 32'd3);
      @(posedge clk);
   endtask

   typedef struct {
      bit          port;
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        flag;
   } vec_t;

   vec_t vecs[16];

   initial begin
      vecs[0]  = '{1'b1, 5'b11100, 32'hFFFFFFFF, 32'd1,        32'd0,          1'b1};
      vecs[1]  = '{1'b1, 5'b11111, 32'hFFFFFFFF, 32'd1,        32'd0,          1'b1};
      vecs[2]  = '{1'b0, 5'b01000, 32'd10,       32'd3,        32'd7,          1'b0};
      vecs[3]  = '{1'b1, 5'b00100, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0,   1'b0};
      vecs[4]  = '{1'b0, 5'b01101, 32'h80000000, 32'd4,        32'hF8000000,   1'b0};
      vecs[5]  = '{1'b0, 5'b00101, 32'h80000000, 32'd4,        32'h08000000,   1'b0};
      vecs[6]  = '{1'b1, 5'b00001, 32'd1,        32'd31,       32'h80000000,   1'b0};
      vecs[7]  = '{1'b0, 5'b00011, 32'd1,        32'hFFFFFFFF, 32'd1,          1'b0};
      vecs[8]  = '{1'b0, 5'b00010, 32'd1,        32'hFFFFFFFF, 32'd0,          1'b0};
      vecs[9]  = '{1'b1, 5'b11000, 32'd7,        32'd7,        32'd0,          1'b1};
      vecs[10] = '{1'b0, 5'b11001, 32'd7,        32'd7,        32'd0,          1'b0};
      vecs[11] = '{1'b1, 5'b00111, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00,   1'b0};
      vecs[12] = '{1'b0, 5'b00110, 32'h000000F0, 32'h0000000F, 32'h000000FF,   1'b0};
      vecs[13] = '{1'b1, 5'b11101, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd0,          1'b1};
      vecs[14] = '{1'b0, 5'b11110, 32'd3,        32'd2,        32'd0,          1'b0};
      vecs[15] = '{1'b1, 5'b11110, 32'd2,        32'd3,        32'd0,          1'b1};

      rst_n = 1'b0;
      req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
      resp0_ready = 1'b0; resp1_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_outputs", {25'b0, busy, resp0_valid, resp1_valid, req0_ready, req1_ready, resp_flag, alu_op_o == 5'd0}, 32'd1);
      chk("rst_result", resp_result, 32'd0);
      chk("rst_alu_a", alu_a_o, 32'd0);
      rst_n = 1'b1;

      contend(1'b0);
      run_op(1'b0, 5'b00000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
      contend(1'b1);

      for (int i = 0; i < 16; i++)
         run_op(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flag, 1'b0);

      // Held response with a competing request waiting.
      @(negedge clk);
      resp0_ready = 1'b0; resp1_ready = 1'b1;
      set_req(1'b0, 1'b1, 5'b00000, 32'd100, 32'd23);
      set_req(1'b1, 1'b1, 5'b01000, 32'd9, 32'd4);
      #1;
      chk("stall_ready", {30'b0, req1_ready, req0_ready}, 32'd1);
      @(posedge clk); #1;
      set_req(1'b0, 1'b0, 5'b0, 32'h0, 32'h0);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stall_valid", {30'b0, resp1_valid, resp0_valid}, 32'd1);
         chk("stall_result", resp_result, 32'd123);
         chk("stall_flag", {31'b0, resp_flag}, 32'd0);
         chk("stall_req1_ready", {31'b0, req1_ready}, 32'd0);
      end
      resp0_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("stall_req1_now_ready", {31'b0, req1_ready}, 32'd1);
      @(posedge clk); #1;
      set_req(1'b1, 1'b0, 5'b0, 32'h0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      chk("stall_req1_resp", {30'b0, resp1_valid, resp0_valid}, 32'd2);
      chk("stall_req1_result", resp_result, 32'd5);
      @(posedge clk);

      // Reset while the operation is in EXEC.
      @(negedge clk);
      set_req(1'b0, 1'b1, 5'b00000, 32'd1, 32'd1);
      @(posedge clk); #1;
      set_req(1'b0, 1'b0, 5'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("mid_exec_busy", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ctrl", {28'b0, busy, resp0_valid, resp1_valid, resp_flag}, 32'd0);
      chk("mid_rst_alu_a", alu_a_o, 32'd0);
      chk("mid_rst_alu_b", alu_b_o, 32'd0);
      chk("mid_rst_result", resp_result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mid_rst_no_resp", {30'b0, resp1_valid, resp0_valid}, 32'd0);
      end
      run_op(1'b0, 5'b01000, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 1'b0);

`ifdef ALU_ARB_OPCHK_EN
      run_op(1'b0, 5'b01111, 32'd3, 32'd5, 32'd0, 1'b0, 1'b1);
      run_op(1'b1, 5'b00000, 32'd3, 32'd5, 32'd8, 1'b0, 1'b0);
`else
      run_op(1'b0, 5'b01111, 32'd3, 32'd5, 32'hDEADBEEF, 1'b0, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
